// File: rtl/cpu_bus_arbiter.sv
// Two-port (I-fetch / D-cache) arbiter for the single external memory bus.
// Define CPU_BUS_ARBITER_RR_EN for round-robin; default build is fixed D-priority.
module cpu_bus_arbiter (
    input  logic        i_clock,
    input  logic        i_reset,

    input  logic        i_i_request,
    input  logic        i_i_rw,
    input  logic [31:0] i_i_address,
    input  logic [31:0] i_i_wdata,
    output logic        o_i_ready,
    output logic [31:0] o_i_rdata,

    input  logic        i_d_request,
    input  logic        i_d_rw,
    input  logic [31:0] i_d_address,
    input  logic [31:0] i_d_wdata,
    output logic        o_d_ready,
    output logic [31:0] o_d_rdata,

    output logic        o_bus_request,
    output logic        o_bus_rw,
    output logic [31:0] o_bus_address,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    state_t state;
    logic   pick_d;

`ifdef CPU_BUS_ARBITER_RR_EN
    // 0 = I-port completed last, 1 = D-port completed last
    logic   last;
`endif

    // Winner among current requesters when leaving IDLE
    always_comb begin
        pick_d = i_d_request;
`ifdef CPU_BUS_ARBITER_RR_EN
        if (i_i_request && i_d_request)
            pick_d = ~last;
`endif
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
`ifdef CPU_BUS_ARBITER_RR_EN
            last  <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_i_request || i_d_request)
                        state <= pick_d ? GRANT_D : GRANT_I;
                end
                GRANT_I: begin
                    if (i_bus_ready) begin
                        state <= HOLDOFF;
`ifdef CPU_BUS_ARBITER_RR_EN
                        last  <= 1'b0;
`endif
                    end else if (!i_i_request) begin
                        state <= HOLDOFF;
                    end
                end
                GRANT_D: begin
                    if (i_bus_ready) begin
                        state <= HOLDOFF;
`ifdef CPU_BUS_ARBITER_RR_EN
                        last  <= 1'b1;
`endif
                    end else if (!i_d_request) begin
                        state <= HOLDOFF;
                    end
                end
                // One dead cycle swallows the request still high on the edge after ready
                HOLDOFF: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Bus side and ready routing follow the grant combinationally
    always_comb begin
        o_bus_request = 1'b0;
        o_bus_rw      = 1'b0;
        o_bus_address = 32'd0;
        o_bus_wdata   = 32'd0;
        o_i_ready     = 1'b0;
        o_d_ready     = 1'b0;
        case (state)
            GRANT_I: begin
                o_bus_request = i_i_request;
                o_bus_rw      = i_i_rw;
                o_bus_address = i_i_address;
                o_bus_wdata   = i_i_wdata;
                o_i_ready     = i_bus_ready;
            end
            GRANT_D: begin
                o_bus_request = i_d_request;
                o_bus_rw      = i_d_rw;
                o_bus_address = i_d_address;
                o_bus_wdata   = i_d_wdata;
                o_d_ready     = i_bus_ready;
            end
            default: ;
        endcase
    end

    assign o_i_rdata = i_bus_rdata;
    assign o_d_rdata = i_bus_rdata;

endmodule
